// File: rtl/trace_pkt_sequencer_if.sv
// trace_pkt_sequencer_if
//   Bundles the two bus-level connections of the trace packet sequencer:
//   the packet read port of the trace input interface (PacketAvail,
//   PacketNext, PacketNextWd, PacketIn) and the valid/ready output stream
//   towards the frame decoder (m_data, m_valid, m_last, m_ready).
//   master : the sequencer side (drives the strobes and the stream)
//   slave  : the environment side (upstream source plus downstream sink)
interface trace_pkt_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              PacketAvail;
    logic              PacketNext;
    logic              PacketNextWd;
    logic [DATA_W-1:0] PacketIn;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport master (
        input  PacketAvail,
        input  PacketIn,
        input  m_ready,
        output PacketNext,
        output PacketNextWd,
        output m_data,
        output m_valid,
        output m_last
    );

    modport slave (
        output PacketAvail,
        output PacketIn,
        output m_ready,
        input  PacketNext,
        input  PacketNextWd,
        input  m_data,
        input  m_valid,
        input  m_last
    );
endinterface

// File: rtl/trace_pkt_sequencer.sv
// trace_pkt_sequencer
//   Reads whole packets from the trace input interface packet port and
//   buffers them in a show-ahead FIFO with last-word marking.
//   A packet is only opened when all of its words fit in the FIFO, so the
//   word reads never have to stall mid-packet.
// Ports:
//   clk        system clock (also the upstream read-side clock)
//   rst        synchronous reset, active low
//   en         allows new packets to be opened
//   bus        packet read port + output stream (master modport)
//   fifo_level FIFO occupancy
//   busy       FSM away from IDLE
//   pkt_count  packets completely read, wraps
//
// state | meaning
// IDLE  | waiting for en, PacketAvail and room for a whole packet
// OPEN  | PacketNext strobe is out (one cycle)
// READ  | PacketNextWd strobe out on each of WORDS_PER_PKT cycles
// DRAIN | final word lands in the FIFO, packet counted
module trace_pkt_sequencer #(
    parameter int WORDS_PER_PKT = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int CNT_W         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    trace_pkt_sequencer_if.master        bus,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         busy,
    output logic [CNT_W-1:0]             pkt_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WC_W  = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;

    localparam logic [WC_W-1:0]  WC_LAST    = WC_W'(WORDS_PER_PKT - 1);
    // Highest occupancy that still leaves room for one full packet.
    localparam logic [LVL_W-1:0] OPEN_LIMIT = LVL_W'(FIFO_DEPTH - WORDS_PER_PKT);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state, stateNext;
    logic [WC_W-1:0]   wordCnt, wordCntNext;
    logic              pktNextQ, pktNextD;
    logic              nextWdQ, nextWdD;
    logic              pktDone;
    logic              spaceOk;

    logic              pend;
    logic [WC_W-1:0]   capIdx;
    logic              push, pushLast, pop, headValid;
    logic [PTR_W-1:0]  wrPtr, rdPtr;
    logic [LVL_W-1:0]  level;
    logic [15:0]       memData [FIFO_DEPTH];
    logic              memLast [FIFO_DEPTH];

    assign spaceOk = (level <= OPEN_LIMIT);

    // FSM state and registered strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wordCnt   <= '0;
            pktNextQ  <= 1'b0;
            nextWdQ   <= 1'b0;
            pkt_count <= '0;
        end else begin
            state    <= stateNext;
            wordCnt  <= wordCntNext;
            pktNextQ <= pktNextD;
            nextWdQ  <= nextWdD;
            if (pktDone) begin
                pkt_count <= pkt_count + CNT_W'(1);
            end
        end
    end

    // Strobes are decided one cycle ahead so they come straight from flops:
    // PacketNext is high exactly while in OPEN, PacketNextWd while in READ.
    always_comb begin
        stateNext   = state;
        wordCntNext = wordCnt;
        pktNextD    = 1'b0;
        nextWdD     = 1'b0;
        pktDone     = 1'b0;
        case (state)
            IDLE: begin
                if (en && bus.PacketAvail && spaceOk) begin
                    stateNext = OPEN;
                    pktNextD  = 1'b1;
                end
            end
            OPEN: begin
                stateNext   = READ;
                nextWdD     = 1'b1;
                wordCntNext = WC_LAST;
            end
            READ: begin
                // Down-counter reaching zero marks the cycle of the last strobe.
                if (wordCnt == '0) begin
                    stateNext = DRAIN;
                end else begin
                    wordCntNext = wordCnt - WC_W'(1);
                    nextWdD     = 1'b1;
                end
            end
            DRAIN: begin
                stateNext = IDLE;
                pktDone   = 1'b1;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Capture pipeline: PacketIn is valid the cycle after each PacketNextWd.
    assign push      = pend;
    assign pushLast  = (capIdx == WC_LAST);
    assign headValid = (level != '0);
    assign pop       = headValid && bus.m_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend   <= 1'b0;
            capIdx <= '0;
            wrPtr  <= '0;
            rdPtr  <= '0;
            level  <= '0;
        end else begin
            pend <= nextWdQ;
            if (push) begin
                wrPtr  <= wrPtr + PTR_W'(1);
                capIdx <= pushLast ? '0 : capIdx + WC_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            memData[wrPtr] <= bus.PacketIn;
            memLast[wrPtr] <= pushLast;
        end
    end

    // Head entry is gated so the stream reads zero while empty and after reset.
    assign bus.m_valid      = headValid;
    assign bus.m_data       = headValid ? memData[rdPtr] : '0;
    assign bus.m_last       = headValid ? memLast[rdPtr] : 1'b0;
    assign bus.PacketNext   = pktNextQ;
    assign bus.PacketNextWd = nextWdQ;
    assign fifo_level       = level;
    assign busy             = (state != IDLE);

    // Space is checked before opening, so an overflowing write means the
    // admission logic is broken.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(pktNextQ && nextWdQ))
                else $error("PacketNext and PacketNextWd asserted together");
            assert (!(push && !pop && level == LVL_FULL))
                else $error("FIFO write with no space");
        end
    end
endmodule

// File: tb/tb_trace_pkt_sequencer.sv
// tb_trace_pkt_sequencer
//   Upstream packet source model, expected-word queue and a per-cycle
//   compare process, driven by a sequence of directed scenarios.
module tb_trace_pkt_sequencer;
    localparam int WPP   = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic [4:0]    fifo_level;
    logic          busy;
    logic [CW-1:0] pkt_count;

    trace_pkt_sequencer_if #(.DATA_W(16)) bus();

    trace_pkt_sequencer #(
        .WORDS_PER_PKT(WPP),
        .FIFO_DEPTH(DEPTH),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .bus(bus),
        .fifo_level(fifo_level),
        .busy(busy),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t        expQ[$];
    logic [15:0] upWords[$];
    int          availPkts = 0;
    logic        availD1 = 1'b0;

    int tests = 0;
    int fails = 0;

    function automatic void ck(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Observation state, owned by the compare process.
    int          cyc = 0;
    int          pnCount, wdCount, lastCount, popCount, maxLevel;
    int          pnCyc, pnGapMin, busyFallCyc;
    int          wdCycles[$];
    logic [15:0] firstPop, lastWord;
    logic        pnS = 1'b0, wdS = 1'b0, prevBusy, holdChk;
    logic [15:0] holdData;
    logic        holdLast;

    always @(negedge clk) begin
        cyc++;
        pnS = bus.PacketNext;
        wdS = bus.PacketNextWd;
        if (!rst) begin
            expQ.delete();
            wdCycles.delete();
            pnCount = 0; wdCount = 0; lastCount = 0; popCount = 0; maxLevel = 0;
            pnCyc = 0; pnGapMin = 1000000; busyFallCyc = -1;
            firstPop = '0; lastWord = '0;
            prevBusy = 1'b0; holdChk = 1'b0;
        end else begin
            ck("strobe_excl", bus.PacketNext && bus.PacketNextWd, 0);
            ck("valid_vs_level", bus.m_valid, fifo_level != 0);
            ck("level_bound", fifo_level <= DEPTH, 1);
            if (holdChk) begin
                ck("hold_valid", bus.m_valid, 1);
                ck("hold_data", bus.m_data, holdData);
                ck("hold_last", bus.m_last, holdLast);
            end
            holdChk  = bus.m_valid && !bus.m_ready;
            holdData = bus.m_data;
            holdLast = bus.m_last;
            if (int'(fifo_level) > maxLevel) maxLevel = int'(fifo_level);
            if (bus.PacketNext) begin
                if (pnCount > 0 && (cyc - pnCyc) < pnGapMin) pnGapMin = cyc - pnCyc;
                pnCyc = cyc;
                pnCount++;
            end
            if (bus.PacketNextWd) begin
                wdCount++;
                wdCycles.push_back(cyc);
            end
            if (prevBusy && !busy) busyFallCyc = cyc;
            prevBusy = busy;
            if (bus.m_valid && bus.m_ready) begin
                if (expQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h expected none", bus.m_data);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    ck("stream_data", bus.m_data, e.data);
                    ck("stream_last", bus.m_last, e.last);
                end
                if (popCount == 0) firstPop = bus.m_data;
                if (bus.m_last) begin
                    lastCount++;
                    lastWord = bus.m_data;
                end
                popCount++;
            end
        end
    end

    // Upstream source: PacketAvail is a two-stage registered view of the
    // number of unopened packets; PacketIn updates after each PacketNextWd.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            upWords.delete();
            availPkts = 0;
            availD1 = 1'b0;
            bus.PacketAvail = 1'b0;
            bus.PacketIn = '0;
        end else begin
            if (pnS) begin
                if (availPkts > 0) availPkts--;
                else begin
                    tests++; fails++;
                    $display("FAIL upstream_open: got PacketNext expected no packet waiting");
                end
            end
            if (wdS) begin
                if (upWords.size() > 0) bus.PacketIn = upWords.pop_front();
                else begin
                    tests++; fails++;
                    $display("FAIL upstream_read: got PacketNextWd expected no word left");
                end
            end
            bus.PacketAvail = availD1;
            availD1 = (availPkts > 0);
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic loadPkt(logic [15:0] base);
        for (int i = 0; i < WPP; i++) begin
            exp_t e;
            e.data = base + 16'(i + 1);
            e.last = (i == WPP - 1);
            upWords.push_back(e.data);
            expQ.push_back(e);
        end
        availPkts++;
    endtask

    task automatic restart();
        rst = 1'b0;
        en = 1'b0;
        bus.m_ready = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic waitPn(int n, int budget);
        int k = 0;
        while (pnCount < n && k < budget) begin
            tick();
            k++;
        end
        ck("wait_packet_next", pnCount >= n, 1);
    endtask

    task automatic checkResetState(string tag);
        ck({tag, "_pnext"}, bus.PacketNext, 0);
        ck({tag, "_pnextwd"}, bus.PacketNextWd, 0);
        ck({tag, "_m_valid"}, bus.m_valid, 0);
        ck({tag, "_m_last"}, bus.m_last, 0);
        ck({tag, "_m_data"}, bus.m_data, 0);
        ck({tag, "_busy"}, busy, 0);
        ck({tag, "_level"}, fifo_level, 0);
        ck({tag, "_pkt_count"}, pkt_count, 0);
    endtask

    initial begin
        bus.m_ready = 1'b0;

        // Reset state
        tick(3);
        @(negedge clk);
        checkResetState("reset");

        // Single packet, timing and content
        tick();
        rst = 1'b1;
        en = 1'b1;
        bus.m_ready = 1'b1;
        loadPkt(16'h1000);
        waitPn(1, 20);
        tick(20);
        ck("single_wd_count", wdCycles.size(), 8);
        ck("single_wd_first", wdCycles.size() > 0 ? wdCycles[0] : -1, pnCyc + 1);
        ck("single_wd_lastcyc", wdCycles.size() == 8 ? wdCycles[7] : -1, pnCyc + 8);
        ck("single_busy_fall", busyFallCyc, pnCyc + 10);
        ck("single_first_word", firstPop, 16'h1001);
        ck("single_last_word", lastWord, 16'h1008);
        ck("single_last_count", lastCount, 1);
        ck("single_pops", popCount, 8);
        ck("single_pkt_count", pkt_count, 1);

        // Backpressure: two packets fill the FIFO, the third waits
        restart();
        en = 1'b1;
        loadPkt(16'h3000);
        loadPkt(16'h3100);
        loadPkt(16'h3200);
        tick(60);
        ck("bp_level_full", fifo_level, 16);
        ck("bp_opened", pnCount, 2);
        ck("bp_third_waiting", bus.PacketAvail, 1);
        ck("bp_pkt_count", pkt_count, 2);
        bus.m_ready = 1'b1;
        tick(8);
        bus.m_ready = 1'b0;
        ck("bp_pops8", popCount, 8);
        tick(40);
        ck("bp_third_opened", pnCount, 3);
        ck("bp_level_refill", fifo_level, 16);
        bus.m_ready = 1'b1;
        tick(30);
        ck("bp_last_pulses", lastCount, 3);
        ck("bp_all_pops", popCount, 24);
        ck("bp_exp_empty", expQ.size(), 0);
        ck("bp_pkt_count3", pkt_count, 3);

        // Back-to-back packets with continuous pop
        restart();
        en = 1'b1;
        bus.m_ready = 1'b1;
        for (int p = 0; p < 4; p++) loadPkt(16'h5000 + 16'(p * 16'h100));
        tick(70);
        ck("b2b_max_level_le2", maxLevel <= 2, 1);
        ck("b2b_pops", popCount, 32);
        ck("b2b_last_pulses", lastCount, 4);
        ck("b2b_pkt_count", pkt_count, 4);
        ck("b2b_min_period", pnGapMin, 11);
        ck("b2b_exp_empty", expQ.size(), 0);

        // Enable dropped mid-READ
        restart();
        en = 1'b1;
        bus.m_ready = 1'b1;
        loadPkt(16'h6000);
        loadPkt(16'h6100);
        waitPn(1, 20);
        begin
            int k = 0;
            while (wdCount < 3 && k < 20) begin
                tick();
                k++;
            end
            ck("en_wait_read", wdCount >= 3, 1);
        end
        en = 1'b0;
        tick(40);
        ck("en_only_one_open", pnCount, 1);
        ck("en_pkt_delivered", popCount, 8);
        ck("en_last_pulse", lastCount, 1);
        ck("en_pkt_count", pkt_count, 1);
        ck("en_avail_pending", bus.PacketAvail, 1);
        ck("en_idle", busy, 0);
        en = 1'b1;
        tick(30);
        ck("en_resumed", pnCount, 2);
        ck("en_resume_pops", popCount, 16);
        ck("en_resume_pkt_count", pkt_count, 2);

        // Reset in the middle of a packet
        restart();
        en = 1'b1;
        bus.m_ready = 1'b1;
        loadPkt(16'h7000);
        waitPn(1, 20);
        tick(5);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkResetState("midreset");
        tick(2);
        rst = 1'b1;
        en = 1'b1;
        bus.m_ready = 1'b1;
        loadPkt(16'h2000);
        tick(30);
        ck("midreset_first_word", firstPop, 16'h2001);
        ck("midreset_last_word", lastWord, 16'h2008);
        ck("midreset_pops", popCount, 8);
        ck("midreset_pkt_count", pkt_count, 1);

        // Counter wrap with a 4-bit counter
        restart();
        en = 1'b1;
        bus.m_ready = 1'b1;
        for (int p = 0; p < 17; p++) loadPkt(16'(p * 16'h10));
        tick(17 * 11 + 30);
        ck("wrap_pkt_count", pkt_count, 1);
        ck("wrap_opened", pnCount, 17);
        ck("wrap_pops", popCount, 136);
        ck("wrap_last_pulses", lastCount, 17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/trace_pkt_sequencer.md
Name: trace_pkt_sequencer

Overview:
- Controller for the trace input interface's packet read port.
- Sequences the PacketNext/PacketNextWd strobes and absorbs the one-cycle read latency on PacketOut.
- Buffers each 8-word frame packet into a small show-ahead FIFO with a valid/ready stream and last-word marking, for the downstream frame decoder or link.
- Only opens a packet when the whole packet fits, so reads never stall mid-packet.

Parameters:
- WORDS_PER_PKT, 8, 16-bit words per packet; must match the trace input interface packet size.
- FIFO_DEPTH, 16, output FIFO entries; power of two, ≥ WORDS_PER_PKT.
- CNT_W, 16, width of the packet statistics counter.

Ports:
- clk  in  1  system clock; also clocks the trace input interface read side.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- en  in  1  enable; when low, no new packet is opened.
- PacketAvail  in  1  packet waiting upstream (registered upstream).
- PacketNext  out  1  one-cycle strobe: advance to next packet.
- PacketNextWd  out  1  one-cycle strobe: fetch next word.
- PacketIn  in  16  upstream PacketOut; valid the cycle after a PacketNextWd.
- m_data  out  16  FIFO head word.
- m_valid  out  1  FIFO non-empty.
- m_last  out  1  head word is the final word of its packet.
- m_ready  in  1  downstream accepts the head word when m_valid & m_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- busy  out  1  FSM not in IDLE.
- pkt_count  out  CNT_W  packets fully read; wraps.

Behaviour:
- Reset (rst=0 at clk edge): FSM=IDLE; FIFO emptied; PacketNext, PacketNextWd, m_valid, m_last, busy = 0; fifo_level = 0; pkt_count = 0; m_data = 0.
- Reset mid-packet abandons the packet immediately. The upstream interface is reset from the same top-level reset, inverted, so no partial state survives.
- PacketNext and PacketNextWd are never asserted in the same cycle. Both are registered outputs.
- FSM states:
  - IDLE: go to OPEN when en & PacketAvail & (FIFO_DEPTH - fifo_level) ≥ WORDS_PER_PKT. Otherwise stay.
  - OPEN: PacketNext=1 for exactly 1 cycle, then READ.
  - READ: PacketNextWd=1 on each of WORDS_PER_PKT consecutive cycles, counted by a word counter. After the last strobe, go to DRAIN.
  - DRAIN: 1 cycle; the final word is captured here. pkt_count += 1, then IDLE.
- Capture pipeline: a pend flag is the 1-cycle-delayed copy of PacketNextWd. When pend=1, PacketIn is written to the FIFO together with last = (capture index == WORDS_PER_PKT-1).
- Timing from IDLE decision at cycle 0:
  - PacketNext at cycle 1.
  - PacketNextWd at cycles 2..9.
  - Words written at the ends of cycles 3..10.
  - IDLE again at cycle 11.
  - Minimum period is 11 cycles per 8-word packet.
- PacketAvail is registered upstream and lags the read pointer by 2 cycles. The ≥2-cycle READ phase guarantees it is current again by the time IDLE re-samples it. No extra holdoff is needed.
- Space check uses fifo_level at the IDLE decision cycle. Downstream pops during a packet only add space. A FIFO write with no space is therefore impossible; an assertion flags it in simulation.
- FIFO is show-ahead:
  - m_data/m_last reflect the head entry whenever m_valid=1.
  - Simultaneous write and pop in one cycle: level unchanged, both take effect.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- en deasserted during OPEN/READ/DRAIN: the current packet completes fully. No new OPEN follows until en=1.
- pkt_count wraps from 2^CNT_W-1 to 0.
- m_valid/m_data hold stable while m_ready=0.

Test Plan:
- Single packet: preload upstream with words 0x1001..0x1008, PacketAvail=1, m_ready=1 → PacketNext at cycle 1; PacketNextWd high cycles 2–9; m_data streams 0x1001..0x1008; m_last only on 0x1008; pkt_count=1; busy low from cycle 11.
- Backpressure: 3 packets available, m_ready=0 → two packets fill the 16-entry FIFO. The third is not opened (PacketNext stays 0). Raising m_ready for 8 pops lets the third open. Output order is intact with 3 m_last pulses.
- Simultaneous push/pop: m_ready=1 throughout back-to-back packets → fifo_level never exceeds 2; no word lost or duplicated across 4 packets; pkt_count=4.
- Enable drop: en→0 at cycle 4 of a READ → that packet's 8 words all delivered. No PacketNext while en=0, even with PacketAvail=1. Resume when en→1.
- Reset mid-packet: rst=0 at cycle 6 → next cycle all strobes 0, m_valid=0, fifo_level=0, pkt_count=0, FSM IDLE. After release, a fresh packet is read cleanly.
- Counter wrap with CNT_W=4: 17 packets → pkt_count reads 1. The PacketNext/PacketNextWd same-cycle assertion never fires.
